// File: rtl/cam_frame_capture_pkg.sv
// Shared types and helpers for the camera capture engine: FSM states, pixel modes,
// and the pixel-format conversion applied before a frame-buffer write.
package cam_frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RGB565 = 2'd0;
    localparam logic [1:0] MODE_RGB332 = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;

    // 8-bit formats land in [7:0]; the reserved mode stores zero.
    function automatic logic [15:0] convert_pixel(input logic [1:0] mode, input logic [15:0] pix);
        logic [15:0] res;
        res = '0;
        case (mode)
            MODE_RGB565: res = pix;
            MODE_RGB332: res = {8'h00, pix[15:13], pix[10:8], pix[4:3]};
            MODE_GRAY:   res = {8'h00, pix[15:8]};
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cam_frame_capture_sync_edge.sv
// Two-flop synchroniser for asynchronous camera strobes, with single-cycle rise/fall
// pulses derived from the synchronised copy.
module cam_frame_capture_sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // NOTE: non-blocking assignments make the three stages shift together; blocking ones
    // would collapse the chain into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/cam_frame_capture.sv
// Camera capture engine: synchronises an OV-style parallel bus, assembles, converts and
// decimates pixels, and writes one whole frame per start request to a frame-buffer port.
module cam_frame_capture
    import cam_frame_capture_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int ADDR_W   = 19,
    parameter int XCLK_DIV = 2,
    parameter int DECIM    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_mode,
    input  logic              i_cam_vsync,
    input  logic              i_cam_href,
    input  logic              i_cam_pclk,
    input  logic [7:0]        i_cam_data,
    output logic              o_cam_xclk,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [15:0]       o_fb_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output logic [ADDR_W-1:0] o_pix_count
);
    localparam int COL_W  = $clog2(H_RES + 1);
    localparam int LINE_W = $clog2(V_RES + 1);
    localparam int DIV_W  = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((H_RES / DECIM) * (V_RES / DECIM) - 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_RES);
    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(V_RES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(XCLK_DIV - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DIV_W-1:0]    r_xclk_cnt;
    logic                r_xclk;
    logic [7:0]          r_data_meta;
    logic [7:0]          r_data_sync;
    logic                r_phase;
    logic [7:0]          r_hi;
    logic [COL_W-1:0]    r_col;
    logic [LINE_W-1:0]   r_line;
    logic                r_vs_seen;
    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [15:0]         r_fb_wdata;
    logic                r_frame_err;
    logic [ADDR_W-1:0]   r_pix_count;

    logic w_vs_level, w_vs_rise, w_vs_fall;
    logic w_href_level, w_href_rise, w_href_fall;
    logic w_pclk_level, w_pclk_rise, w_pclk_fall;
    logic w_pixel_done, w_keep, w_store, w_last_store, w_set_err;

    cam_frame_capture_sync_edge #(.WIDTH(1)) u_sync_vsync (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cam_vsync),
        .o_level(w_vs_level), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
    );
    cam_frame_capture_sync_edge #(.WIDTH(1)) u_sync_href (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cam_href),
        .o_level(w_href_level), .o_rise(w_href_rise), .o_fall(w_href_fall)
    );
    cam_frame_capture_sync_edge #(.WIDTH(1)) u_sync_pclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cam_pclk),
        .o_level(w_pclk_level), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
    );

    logic w_unused_edges;
    assign w_unused_edges = &{1'b0, w_href_rise, w_pclk_level, w_pclk_fall};

    // Data takes the same two-flop delay so it lines up with the synchronised pclk edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_data_meta <= i_cam_data;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xclk_cnt <= '0;
            r_xclk     <= 1'b0;
        end else if (r_xclk_cnt == DIV_LAST) begin
            r_xclk_cnt <= '0;
            r_xclk     <= ~r_xclk;
        end else begin
            r_xclk_cnt <= r_xclk_cnt + DIV_W'(1);
        end
    end

    assign w_pixel_done = (r_state == ST_CAPTURE) && w_pclk_rise && w_href_level && r_phase;
    assign w_keep       = (r_col < COL_END) && (r_line < LINE_END) &&
                          ((int'(r_col) % DECIM) == 0) && ((int'(r_line) % DECIM) == 0);
    assign w_store      = w_pixel_done && w_keep && !i_abort;
    assign w_last_store = w_store && (r_pix_count == LAST_ADDR);
    assign w_set_err    = (r_state == ST_CAPTURE) && !i_abort && !w_last_store && w_vs_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = ST_ARM;
            end
            ST_ARM: begin
                o_busy = 1'b1;
                if (i_abort)                     w_next_state = ST_IDLE;
                else if (w_vs_fall && r_vs_seen) w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                o_busy = 1'b1;
                if (i_abort)                      w_next_state = ST_IDLE;
                else if (w_last_store || w_set_err) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Arming only counts a vsync pulse that is seen high after the start request.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != ST_ARM) r_vs_seen <= 1'b0;
        else if (w_vs_level)            r_vs_seen <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != ST_CAPTURE) begin
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_col   <= '0;
            r_line  <= '0;
        end else if (w_href_fall) begin
            r_phase <= 1'b0;
            r_col   <= '0;
            if (r_line < LINE_END) r_line <= r_line + LINE_W'(1);
        end else if (w_pclk_rise && w_href_level) begin
            r_phase <= ~r_phase;
            if (!r_phase)               r_hi  <= r_data_sync;
            else if (r_col < COL_END)   r_col <= r_col + COL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fb_we     <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_wdata  <= '0;
            r_frame_err <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_fb_we <= w_store;
            if (r_state == ST_IDLE && i_start) begin
                r_frame_err <= 1'b0;
                r_pix_count <= '0;
            end else if (w_store) begin
                r_fb_addr   <= r_pix_count;
                r_fb_wdata  <= convert_pixel(i_mode, {r_hi, r_data_sync});
                r_pix_count <= r_pix_count + ADDR_W'(1);
            end
            if (w_set_err) r_frame_err <= 1'b1;
        end
    end

    assign o_cam_xclk  = r_xclk;
    assign o_fb_we     = r_fb_we;
    assign o_fb_addr   = r_fb_addr;
    assign o_fb_wdata  = r_fb_wdata;
    assign o_frame_err = r_frame_err;
    assign o_pix_count = r_pix_count;

endmodule
